// File: rtl/regfile_arb_pkg.sv
// ----------------------------------------------------------------------------
// regfile_arb_pkg
//   Shared definitions for the register-file arbiter: opcode encodings, the
//   controller state enum, and a helper that maps an accepted opcode onto the
//   first state of its execution sequence.
//
//   Contents:
//     op_e            request opcode (READ / WRITE / COPY / ILLEGAL)
//     state_e         controller states
//     RF_ADDR_W       register-file address width (R0..R15)
//     ID_W            width of a requester index
//     op_entry_state  opcode -> first state after acceptance
// ----------------------------------------------------------------------------
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_COPY    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_COPY_RD = 3'd3,
    ST_COPY_WR = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  localparam int RF_ADDR_W = 4;
  localparam int ID_W      = 2;

  // Illegal opcodes skip the register file entirely and go straight to the
  // response state, which gives them their single-cycle latency.
  function automatic state_e op_entry_state(input logic [1:0] op);
    state_e st;
    case (op)
      OP_READ:  st = ST_READ;
      OP_WRITE: st = ST_WRITE;
      OP_COPY:  st = ST_COPY_RD;
      default:  st = ST_RESP;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin selector. The search starts at the
//   requester after the last one granted and wraps around, so a requester
//   that keeps its request asserted is served at most once per round.
//
//   Ports:
//     req         in   NREQ   request bits
//     last_grant  in   ID_W   index of the most recently granted requester
//     grant       out  NREQ   one-hot grant (all zero when no request)
//     grant_idx   out  ID_W   index of the granted requester (0 when none)
// ----------------------------------------------------------------------------
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last_grant,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx
);

  logic [ID_W-1:0] w_cand;
  logic            w_found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    // Visit last_grant+1, last_grant+2, ... and finally last_grant itself.
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = ID_W'((int'(last_grant) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        grant[w_cand] = 1'b1;
        grant_idx     = w_cand;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_arbiter
//   Shares one external R0..R15 register file between NREQ requesters.
//   Requests are accepted one at a time (round-robin, only while idle) and
//   executed as READ, WRITE, COPY (read then write back) or rejected as
//   illegal. Every accepted request finishes with a one-cycle response pulse.
//
//   Ports:
//     clk            in   1              clock, rising edge
//     reset_n        in   1              asynchronous active-low reset
//     req_valid      in   NREQ           per-requester request valid
//     req_ready      out  NREQ           one-hot accept strobe
//     req_op         in   2*NREQ         per-requester opcode
//     req_dst        in   4*NREQ         per-requester destination register
//     req_src        in   4*NREQ         per-requester source register
//     req_wdata      in   DATA_W*NREQ    per-requester write data
//     rsp_valid      out  1              completion pulse
//     rsp_id         out  2              completing requester
//     rsp_data       out  DATA_W         read / written value, 0 for illegal
//     rsp_err        out  1              illegal opcode completion
//     busy           out  1              controller not idle
//     rf_addr_in     out  4              register-file write address
//     rf_addr_out    out  4              register-file read address
//     rf_load        out  1              register-file write enable
//     rf_enable_out  out  1              register-file read enable
//     rf_data_in     out  DATA_W         register-file write data
//     rf_data_out    in   DATA_W         register-file read data
// ----------------------------------------------------------------------------
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [4*NREQ-1:0]      req_dst,
  input  logic [4*NREQ-1:0]      req_src,
  input  logic [DATA_W*NREQ-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [RF_ADDR_W-1:0]   rf_addr_in,
  output logic [RF_ADDR_W-1:0]   rf_addr_out,
  output logic                   rf_load,
  output logic                   rf_enable_out,
  output logic [DATA_W-1:0]      rf_data_in,
  input  logic [DATA_W-1:0]      rf_data_out
);

  // --------------------------------------------------------------------------
  // State and latched request
  // --------------------------------------------------------------------------
  state_e                r_state;
  state_e                w_state_next;
  logic [ID_W-1:0]       r_last_grant;
  logic [1:0]            r_op;
  logic [RF_ADDR_W-1:0]  r_dst;
  logic [RF_ADDR_W-1:0]  r_src;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_hold;
  logic [ID_W-1:0]       r_id;

  // --------------------------------------------------------------------------
  // Per-requester field views
  // --------------------------------------------------------------------------
  logic [1:0]            w_op_arr    [NREQ];
  logic [RF_ADDR_W-1:0]  w_dst_arr   [NREQ];
  logic [RF_ADDR_W-1:0]  w_src_arr   [NREQ];
  logic [DATA_W-1:0]     w_wdata_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_op_arr[gi]    = req_op[gi*2 +: 2];
      assign w_dst_arr[gi]   = req_dst[gi*RF_ADDR_W +: RF_ADDR_W];
      assign w_src_arr[gi]   = req_src[gi*RF_ADDR_W +: RF_ADDR_W];
      assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic [NREQ-1:0]       w_grant;
  logic [ID_W-1:0]       w_grant_idx;
  logic                  w_accept;
  logic [1:0]            w_sel_op;

  rr_arbiter #(
    .NREQ       (NREQ)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx)
  );

  // reset_n is folded in so req_ready is also held low combinationally while
  // reset is asserted, even though the state already reads as idle.
  assign w_accept  = reset_n && (r_state == ST_IDLE) && (|w_grant);
  assign req_ready = w_accept ? w_grant : '0;
  assign w_sel_op  = w_op_arr[w_grant_idx];
  assign busy      = (r_state != ST_IDLE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Request latch, last grant and read-data hold register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= ID_W'(NREQ - 1);
      r_op         <= '0;
      r_dst        <= '0;
      r_src        <= '0;
      r_wdata      <= '0;
      r_id         <= '0;
      r_hold       <= '0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant_idx;
        r_id         <= w_grant_idx;
        r_op         <= w_sel_op;
        r_dst        <= w_dst_arr[w_grant_idx];
        r_src        <= w_src_arr[w_grant_idx];
        r_wdata      <= w_wdata_arr[w_grant_idx];
      end
      // The register file read is combinational, so the value is captured at
      // the end of the cycle in which the read enable is presented.
      if ((r_state == ST_READ) || (r_state == ST_COPY_RD)) begin
        r_hold <= rf_data_out;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    rf_load       = 1'b0;
    rf_enable_out = 1'b0;
    rf_addr_in    = '0;
    rf_addr_out   = '0;
    rf_data_in    = '0;
    rsp_valid     = 1'b0;
    rsp_id        = '0;
    rsp_data      = '0;
    rsp_err       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = op_entry_state(w_sel_op);
        end
      end

      ST_WRITE: begin
        rf_load      = 1'b1;
        rf_addr_in   = r_dst;
        rf_data_in   = r_wdata;
        w_state_next = ST_RESP;
      end

      ST_READ: begin
        rf_enable_out = 1'b1;
        rf_addr_out   = r_src;
        w_state_next  = ST_RESP;
      end

      ST_COPY_RD: begin
        rf_enable_out = 1'b1;
        rf_addr_out   = r_src;
        w_state_next  = ST_COPY_WR;
      end

      ST_COPY_WR: begin
        rf_load      = 1'b1;
        rf_addr_in   = r_dst;
        rf_data_in   = r_hold;
        w_state_next = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = r_id;
        rsp_err   = (r_op == OP_ILLEGAL);
        // WRITE reports the value written; READ and COPY report the value
        // read (held in r_hold); illegal reports zero.
        if (r_op == OP_WRITE) begin
          rsp_data = r_wdata;
        end else if (r_op == OP_ILLEGAL) begin
          rsp_data = '0;
        end else begin
          rsp_data = r_hold;
        end
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Structural invariants
  // --------------------------------------------------------------------------
  a_no_load_and_read : assert property (
    @(posedge clk) disable iff (!reset_n) !(rf_load && rf_enable_out));

  a_ready_onehot : assert property (
    @(posedge clk) disable iff (!reset_n) $onehot0(req_ready));

endmodule

// File: tb/tb_regfile_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_arbiter
//   Directed bench for regfile_arbiter with an attached register-file model.
//   A transaction-level reference (round-robin choice, per-opcode schedule of
//   read / write / response slots, and a shadow copy of R0..R15) predicts
//   every output at every falling edge; directed sequences add hand-computed
//   literal expectations.
// ----------------------------------------------------------------------------
module tb_regfile_arbiter;

  localparam int NREQ   = 3;
  localparam int DATA_W = 32;

  localparam int OPR = 0;
  localparam int OPW = 1;
  localparam int OPC = 2;
  localparam int OPX = 3;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [2*NREQ-1:0]      req_op;
  logic [4*NREQ-1:0]      req_dst;
  logic [4*NREQ-1:0]      req_src;
  logic [DATA_W*NREQ-1:0] req_wdata;
  logic                   rsp_valid;
  logic [1:0]             rsp_id;
  logic [DATA_W-1:0]      rsp_data;
  logic                   rsp_err;
  logic                   busy;
  logic [3:0]             rf_addr_in;
  logic [3:0]             rf_addr_out;
  logic                   rf_load;
  logic                   rf_enable_out;
  logic [DATA_W-1:0]      rf_data_in;
  logic [DATA_W-1:0]      rf_data_out;

  regfile_arbiter #(
    .NREQ          (NREQ),
    .DATA_W        (DATA_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_dst       (req_dst),
    .req_src       (req_src),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .busy          (busy),
    .rf_addr_in    (rf_addr_in),
    .rf_addr_out   (rf_addr_out),
    .rf_load       (rf_load),
    .rf_enable_out (rf_enable_out),
    .rf_data_in    (rf_data_in),
    .rf_data_out   (rf_data_out)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, combinational read.
  logic [31:0] rf_mem [16] = '{default: 32'h0};
  always @(posedge clk) begin
    if (rf_load) rf_mem[rf_addr_in] <= rf_data_in;
  end
  assign rf_data_out = rf_enable_out ? rf_mem[rf_addr_out] : 32'h0;

  // --------------------------------------------------------------------------
  // Check bookkeeping
  // --------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  int          m_last = NREQ - 1;
  bit          m_active = 1'b0;
  int          m_age, m_id, m_op, m_dst, m_src;
  int          m_rd_slot, m_wr_slot, m_rsp_slot;
  logic [31:0] m_wdata, m_data;
  logic [31:0] m_regs [16] = '{default: 32'h0};

  always @(negedge clk) begin : compare
    logic [NREQ-1:0] e_ready;
    logic            e_busy, e_load, e_en, e_rv, e_err;
    logic [3:0]      e_ain, e_aout;
    logic [31:0]     e_din, e_rd;
    logic [1:0]      e_id;
    int              j;
    e_ready = '0; e_busy = 1'b0; e_load = 1'b0; e_en = 1'b0; e_rv = 1'b0; e_err = 1'b0;
    e_ain = '0; e_aout = '0; e_din = '0; e_rd = '0; e_id = '0;

    if (!reset_n) begin
      m_active = 1'b0;
      m_last   = NREQ - 1;
    end else if (!m_active) begin
      for (int k = 1; k <= NREQ; k++) begin
        j = (m_last + k) % NREQ;
        if (!m_active && req_valid[j]) begin
          e_ready[j] = 1'b1;
          m_active   = 1'b1;
          m_age      = 0;
          m_id       = j;
          m_last     = j;
          m_op       = int'(req_op[j*2 +: 2]);
          m_dst      = int'(req_dst[j*4 +: 4]);
          m_src      = int'(req_src[j*4 +: 4]);
          m_wdata    = req_wdata[j*32 +: 32];
          // Cycle (counted from acceptance) of read, write and response.
          case (m_op)
            OPR:     begin m_rd_slot = 1; m_wr_slot = 0; m_rsp_slot = 2; end
            OPW:     begin m_rd_slot = 0; m_wr_slot = 1; m_rsp_slot = 2; end
            OPC:     begin m_rd_slot = 1; m_wr_slot = 2; m_rsp_slot = 3; end
            default: begin m_rd_slot = 0; m_wr_slot = 0; m_rsp_slot = 1; end
          endcase
        end
      end
    end else begin
      m_age++;
      e_busy = 1'b1;
      if (m_age == m_rd_slot) begin
        e_en   = 1'b1;
        e_aout = 4'(m_src);
        m_data = m_regs[m_src];
      end
      if (m_age == m_wr_slot) begin
        e_load = 1'b1;
        e_ain  = 4'(m_dst);
        e_din  = (m_op == OPW) ? m_wdata : m_data;
        m_regs[m_dst] = e_din;
      end
      if (m_age == m_rsp_slot) begin
        e_rv  = 1'b1;
        e_id  = 2'(m_id);
        e_err = (m_op == OPX);
        e_rd  = (m_op == OPX) ? 32'h0 : ((m_op == OPW) ? m_wdata : m_data);
        m_active = 1'b0;
        $display("rsp id=%0d op=%0d data=0x%08h err=%0d t=%0t", m_id, m_op, e_rd, e_err, $time);
      end
    end

    chk("req_ready",     32'(req_ready),     32'(e_ready));
    chk("busy",          32'(busy),          32'(e_busy));
    chk("rf_load",       32'(rf_load),       32'(e_load));
    chk("rf_enable_out", 32'(rf_enable_out), 32'(e_en));
    chk("rf_addr_in",    32'(rf_addr_in),    32'(e_ain));
    chk("rf_addr_out",   32'(rf_addr_out),   32'(e_aout));
    chk("rf_data_in",    rf_data_in,         e_din);
    chk("rsp_valid",     32'(rsp_valid),     32'(e_rv));
    chk("rsp_id",        32'(rsp_id),        32'(e_id));
    chk("rsp_data",      rsp_data,           e_rd);
    chk("rsp_err",       32'(rsp_err),       32'(e_err));
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  logic        cap_load [5];
  logic        cap_en   [5];
  logic        cap_rv   [5];
  logic        cap_err  [5];
  logic [3:0]  cap_ain  [5];
  logic [3:0]  cap_aout [5];
  logic [31:0] cap_din  [5];
  logic [31:0] cap_rd   [5];
  logic [1:0]  cap_id   [5];

  task automatic set_req(input int id, input int op, input int dst, input int src, input logic [31:0] wd);
    req_op[id*2 +: 2]     = 2'(op);
    req_dst[id*4 +: 4]    = 4'(dst);
    req_src[id*4 +: 4]    = 4'(src);
    req_wdata[id*32 +: 32] = wd;
  endtask

  task automatic wait_accept(input int id, input string name);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    chk(name, 32'(got), 1);
  endtask

  // Issue one request from a single requester and capture cycles t+1..t+4.
  task automatic run_op(input int id, input int op, input int dst, input int src, input logic [31:0] wd);
    @(posedge clk); #1;
    set_req(id, op, dst, src, wd);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    wait_accept(id, "accept");
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      else       @(negedge clk);
      cap_load[k] = rf_load;   cap_en[k]   = rf_enable_out;
      cap_ain[k]  = rf_addr_in; cap_aout[k] = rf_addr_out;
      cap_din[k]  = rf_data_in; cap_rv[k]   = rsp_valid;
      cap_rd[k]   = rsp_data;   cap_id[k]   = rsp_id;
      cap_err[k]  = rsp_err;
    end
  endtask

  int   gr_order [6];
  int   exp_order [6] = '{0, 1, 2, 0, 1, 2};
  int   n_gr;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = '0; req_op = '0; req_dst = '0; req_src = '0; req_wdata = '0;

    // Reset: outputs low even with a request pending.
    repeat (2) @(posedge clk);
    #1 req_valid = 3'b001;
    #1;
    chk("rst_ready",   32'(req_ready), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_rsp",     32'(rsp_valid), 0);
    chk("rst_load",    32'(rf_load), 0);
    chk("rst_en",      32'(rf_enable_out), 0);
    chk("rst_data",    rsp_data, 0);
    req_valid = '0;
    reset_n   = 1'b1;

    // WRITE R5 from requester 0.
    run_op(0, OPW, 5, 0, 32'hDEADBEEF);
    chk("w_load_t1", 32'(cap_load[1]), 1);
    chk("w_ain_t1",  32'(cap_ain[1]), 5);
    chk("w_din_t1",  cap_din[1], 32'hDEADBEEF);
    chk("w_en_t1",   32'(cap_en[1]), 0);
    chk("w_rv_t1",   32'(cap_rv[1]), 0);
    chk("w_rv_t2",   32'(cap_rv[2]), 1);
    chk("w_id_t2",   32'(cap_id[2]), 0);
    chk("w_data_t2", cap_rd[2], 32'hDEADBEEF);

    // READ R5 from requester 1.
    run_op(1, OPR, 0, 5, 32'h0);
    chk("r_en_t1",   32'(cap_en[1]), 1);
    chk("r_aout_t1", 32'(cap_aout[1]), 5);
    chk("r_load_t1", 32'(cap_load[1]), 0);
    chk("r_rv_t2",   32'(cap_rv[2]), 1);
    chk("r_id_t2",   32'(cap_id[2]), 1);
    chk("r_data_t2", cap_rd[2], 32'hDEADBEEF);

    // COPY R5 -> R9 from requester 2.
    run_op(2, OPC, 9, 5, 32'h0);
    chk("c_en_t1",   32'(cap_en[1]), 1);
    chk("c_load_t2", 32'(cap_load[2]), 1);
    chk("c_ain_t2",  32'(cap_ain[2]), 9);
    chk("c_din_t2",  cap_din[2], 32'hDEADBEEF);
    chk("c_rv_t2",   32'(cap_rv[2]), 0);
    chk("c_rv_t3",   32'(cap_rv[3]), 1);
    chk("c_data_t3", cap_rd[3], 32'hDEADBEEF);

    // READ R9 back.
    run_op(0, OPR, 0, 9, 32'h0);
    chk("r9_data_t2", cap_rd[2], 32'hDEADBEEF);

    // COPY with src == dst rewrites the same value.
    run_op(1, OPC, 9, 9, 32'h0);
    chk("cs_din_t2",  cap_din[2], 32'hDEADBEEF);
    chk("cs_data_t3", cap_rd[3], 32'hDEADBEEF);

    // Illegal opcode.
    run_op(2, OPX, 1, 1, 32'h1234);
    chk("x_load_t1", 32'(cap_load[1]), 0);
    chk("x_en_t1",   32'(cap_en[1]), 0);
    chk("x_rv_t1",   32'(cap_rv[1]), 1);
    chk("x_err_t1",  32'(cap_err[1]), 1);
    chk("x_data_t1", cap_rd[1], 0);
    chk("x_id_t1",   32'(cap_id[1]), 2);
    chk("x_rv_t2",   32'(cap_rv[2]), 0);

    // No requests: stays idle.
    repeat (3) @(negedge clk);
    chk("idle_ready", 32'(req_ready), 0);
    chk("idle_busy",  32'(busy), 0);

    // Reset during COPY_WR drops the operation.
    @(posedge clk); #1;
    set_req(0, OPC, 12, 5, 32'h0);
    req_valid = 3'b001;
    wait_accept(0, "accept_cw");
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk("cw_load_pre", 32'(rf_load), 1);
    chk("cw_ain_pre",  32'(rf_addr_in), 12);
    reset_n = 1'b0;
    #1;
    chk("cw_load_rst", 32'(rf_load), 0);
    chk("cw_busy_rst", 32'(busy), 0);
    chk("cw_rv_rst",   32'(rsp_valid), 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("cw_busy_post", 32'(busy), 0);
    chk("cw_rv_post",   32'(rsp_valid), 0);
    run_op(1, OPR, 0, 12, 32'h0);
    chk("cw_r12_rv",   32'(cap_rv[2]), 1);
    chk("cw_r12_data", cap_rd[2], 0);

    // Round robin with all requesters continuously valid from reset.
    @(posedge clk); #1;
    reset_n = 1'b0;
    set_req(0, OPW, 10, 0, 32'h000000A0);
    set_req(1, OPR, 0, 10, 32'h0);
    set_req(2, OPX, 0, 0, 32'h0);
    req_valid = 3'b111;
    @(posedge clk); #1;
    chk("rr_rst_ready", 32'(req_ready), 0);
    reset_n = 1'b1;
    n_gr = 0;
    for (int c = 0; c < 100 && n_gr < 6; c++) begin
      @(negedge clk);
      for (int k = 0; k < NREQ; k++) begin
        if (req_ready[k]) begin
          gr_order[n_gr] = k;
          n_gr++;
        end
      end
    end
    chk("rr_count", 32'(n_gr), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_order%0d", i), 32'(gr_order[i]), 32'(exp_order[i]));
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (6) @(negedge clk);
    chk("end_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requesters (2..4).
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester request valid.
REQ-006 SHALL have port req_ready  output  NREQ  one-hot accept pulse; request i is accepted in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-007 SHALL have port req_op  input  2*NREQ  per-requester opcode: 00 READ, 01 WRITE, 10 COPY, 11 illegal.
REQ-008 SHALL have port req_dst  input  4*NREQ  per-requester destination register R0-R15.
REQ-009 SHALL have port req_src  input  4*NREQ  per-requester source register R0-R15.
REQ-010 SHALL have port req_wdata  input  DATA_W*NREQ  per-requester write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-012 SHALL have port rsp_id  output  2  index of the completing requester.
REQ-013 SHALL have port rsp_data  output  DATA_W  READ/COPY: value read; WRITE: value written; illegal: 0.
REQ-014 SHALL have port rsp_err  output  1  1 only on completion of an illegal opcode.
REQ-015 SHALL have port busy  output  1  1 whenever the FSM is not in IDLE.
REQ-016 SHALL have ports rf_addr_in (output, 4), rf_addr_out (output, 4), rf_load (output, 1), rf_enable_out (output, 1), rf_data_in (output, DATA_W) and rf_data_out (input, DATA_W), which drive the R0-R15 register file.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, READ, COPY_RD, COPY_WR and RESP.
REQ-018 SHALL arbitrate only in IDLE, asserting at most one req_ready bit, selected round-robin starting at (last_grant+1) mod NREQ.
REQ-019 SHALL update last_grant only on acceptance, and SHALL latch op, dst, src, wdata and id in the accept cycle.
REQ-020 SHALL transition on acceptance from IDLE to WRITE (op 01), READ (op 00), COPY_RD (op 10) or RESP (op 11).
REQ-021 SHALL, in WRITE, drive rf_load=1, rf_addr_in=dst and rf_data_in=wdata for exactly one cycle, then go to RESP.
REQ-022 SHALL, in READ, drive rf_enable_out=1 and rf_addr_out=src, capture rf_data_out at the end of that cycle, then go to RESP.
REQ-023 SHALL, in COPY_RD, do the same as READ into an internal hold register, then go to COPY_WR.
REQ-024 SHALL, in COPY_WR, drive rf_load=1, rf_addr_in=dst and rf_data_in=hold for one cycle, then go to RESP.
REQ-025 SHALL, in RESP, assert rsp_valid, rsp_id, rsp_data and rsp_err for one cycle, then return to IDLE; no acceptance occurs in RESP.
REQ-026 SHALL have latency, measured from accept cycle t to the rsp_valid cycle, of t+2 for READ and WRITE, t+3 for COPY and t+1 for illegal.
REQ-027 SHALL drive rf_load, rf_enable_out, rf_addr_in, rf_addr_out and rf_data_in to 0 outside the states named above, and SHALL never assert rf_load and rf_enable_out in the same cycle.
REQ-028 SHALL treat COPY with src==dst as normal (read then rewrite the same value).
REQ-029 SHALL issue no req_ready when no req_valid bit is set; the FSM stays in IDLE.
REQ-030 SHALL hold rsp_data, rsp_id and rsp_err at 0 when rsp_valid=0.

Reset
REQ-031 SHALL, while reset_n=0, force the state to IDLE, last_grant to NREQ-1, the hold register to 0 and every output to 0, asynchronously.
REQ-032 SHALL, on reset mid-operation, drop the operation with no response and remove rf_load immediately.

Structure
REQ-033 SHALL take opcode encodings and the FSM state enum from shared package regfile_arb_pkg.
REQ-034 SHALL place round-robin selection in sub-module rr_arbiter, with inputs req/last_grant and outputs grant one-hot/grant_idx.

Verification
REQ-035 SHALL cover: after reset, R0 write request (req 0, dst=5, wdata=0xDEADBEEF) -> rf_load=1 at t+1 with addr_in=5 and data_in=0xDEADBEEF; rsp_valid at t+2 with id=0 and data=0xDEADBEEF.
REQ-036 SHALL cover: READ src=5 after the write above -> rf_enable_out=1 and addr_out=5 at t+1; rsp_data=0xDEADBEEF at t+2.
REQ-037 SHALL cover: COPY src=5, dst=9 -> enable_out at t+1, load with addr_in=9 and data 0xDEADBEEF at t+2, rsp at t+3; a subsequent READ of R9 returns 0xDEADBEEF.
REQ-038 SHALL cover: all three requesters valid continuously, starting just after reset -> grants in order 0,1,2,0,1,2, with no requester granted twice before the others.
REQ-039 SHALL cover: opcode 11 -> no rf_load and no rf_enable_out; rsp_err=1 and rsp_data=0 at t+1.
REQ-040 SHALL cover: reset_n low during COPY_WR -> rf_load drops immediately, no rsp_valid, and the FSM is in IDLE with busy=0 after release.
